// File: rtl/synth_voice_pkg.sv
// synth_voice_pkg
// Shared types and defaults for the synthesizer voice allocator.
//   voice_state_t : per-slot voice state (FREE / HELD / RELEASING)
//   alloc_state_t : allocator controller state (IDLE / SCAN / COMMIT)
//   DEFAULT_NOTE_W: default MIDI note / velocity width
package synth_voice_pkg;

    localparam int DEFAULT_NOTE_W = 7;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        HELD      = 2'd1,
        RELEASING = 2'd2
    } voice_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_t;

endpackage

// File: rtl/voice_alloc_slot.sv
// voice_alloc_slot
// One voice slot: state, note, velocity, saturating age and trigger pulse.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   load            : assign this slot (goes HELD, loads note/vel, age 0, trig)
//   load_note/vel   : values loaded on load
//   release_req     : HELD -> RELEASING (note-off for this slot's note)
//   done            : envelope finished; RELEASING -> FREE
//   age_inc         : another slot was assigned; age this one if not FREE
//   state/note/vel/age/trig : slot outputs
module voice_alloc_slot
    import synth_voice_pkg::*;
#(
    parameter int NOTE_W = DEFAULT_NOTE_W,
    parameter int AGE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [NOTE_W-1:0] load_note,
    input  logic [NOTE_W-1:0] load_vel,
    input  logic              release_req,
    input  logic              done,
    input  logic              age_inc,
    output voice_state_t      state,
    output logic [NOTE_W-1:0] note,
    output logic [NOTE_W-1:0] vel,
    output logic [AGE_W-1:0]  age,
    output logic              trig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
            note  <= '0;
            vel   <= '0;
            age   <= '0;
            trig  <= 1'b0;
        end else begin
            trig <= load;
            // An assignment in the same cycle as a done pulse wins.
            if (load) begin
                state <= HELD;
                note  <= load_note;
                vel   <= load_vel;
                age   <= '0;
            end else if (done && state == RELEASING) begin
                state <= FREE;
                age   <= '0;
            end else begin
                if (release_req && state == HELD)
                    state <= RELEASING;
                if (age_inc && state != FREE && age != {AGE_W{1'b1}})
                    age <= age + 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic voice allocator. Accepts note-on/off events over valid/ready,
// scans the voice slots one per cycle, then commits the event in one cycle.
// Optional feature macro: VOICE_STEAL_EN (steal oldest RELEASING, else oldest
// HELD, slot when no match and no FREE slot exist; otherwise the note-on is
// dropped and ev_dropped pulses).
// Ports:
//   clk_clk, reset_reset       : clock, asynchronous active-high reset
//   ev_valid/ev_ready          : event handshake (ready only in IDLE)
//   ev_on, ev_note, ev_vel     : event payload (note-on vel 0 = note-off)
//   voice_done                 : per-voice envelope release finished
//   voice_gate/trig            : per-voice key-down / envelope start pulse
//   voice_note/vel             : per-voice packed note/velocity
//   ev_dropped                 : note-on discarded pulse
module voice_allocator
    import synth_voice_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_W     = DEFAULT_NOTE_W,
    parameter int AGE_W      = 8
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NOTE_W-1:0]            ev_vel,
    input  logic [NUM_VOICES-1:0]        voice_done,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_vel,
    output logic                         ev_dropped
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

`ifdef VOICE_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    alloc_state_t state, next_state;

    logic              ev_on_q;
    logic [NOTE_W-1:0] ev_note_q;
    logic [NOTE_W-1:0] ev_vel_q;
    logic [IDX_W-1:0]  scan_idx;

    logic              match_found, free_found, rel_found, held_found;
    logic [IDX_W-1:0]  match_idx, free_idx, rel_idx, held_idx;
    logic [AGE_W-1:0]  rel_age, held_age;

    voice_state_t      slot_state [NUM_VOICES];
    logic [NOTE_W-1:0] slot_note  [NUM_VOICES];
    logic [NOTE_W-1:0] slot_vel   [NUM_VOICES];
    logic [AGE_W-1:0]  slot_age   [NUM_VOICES];
    logic [NUM_VOICES-1:0] slot_trig;

    logic                  do_load, drop;
    logic [IDX_W-1:0]      target;
    logic [NUM_VOICES-1:0] load_vec, release_vec;

    logic scan_last;
    assign scan_last = (scan_idx == IDX_W'(NUM_VOICES - 1));
    assign ev_ready  = (state == IDLE);

    // Controller state register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ev_valid) next_state = SCAN;
            SCAN:    if (scan_last) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Event latch and candidate tracking over the scan
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            ev_vel_q    <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            rel_found   <= 1'b0;
            held_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            rel_idx     <= '0;
            held_idx    <= '0;
            rel_age     <= '0;
            held_age    <= '0;
            ev_dropped  <= 1'b0;
        end else begin
            ev_dropped <= (state == COMMIT) && drop;
            if (state == IDLE && ev_valid) begin
                // Zero velocity on a note-on is a note-off.
                ev_on_q     <= ev_on && (ev_vel != '0);
                ev_note_q   <= ev_note;
                ev_vel_q    <= ev_vel;
                scan_idx    <= '0;
                match_found <= 1'b0;
                free_found  <= 1'b0;
                rel_found   <= 1'b0;
                held_found  <= 1'b0;
            end else if (state == SCAN) begin
                if (!match_found && slot_state[scan_idx] != FREE &&
                    slot_note[scan_idx] == ev_note_q) begin
                    match_found <= 1'b1;
                    match_idx   <= scan_idx;
                end
                if (!free_found && slot_state[scan_idx] == FREE) begin
                    free_found <= 1'b1;
                    free_idx   <= scan_idx;
                end
                // Strictly-greater keeps the lowest index on age ties.
                if (slot_state[scan_idx] == RELEASING &&
                    (!rel_found || slot_age[scan_idx] > rel_age)) begin
                    rel_found <= 1'b1;
                    rel_idx   <= scan_idx;
                    rel_age   <= slot_age[scan_idx];
                end
                if (slot_state[scan_idx] == HELD &&
                    (!held_found || slot_age[scan_idx] > held_age)) begin
                    held_found <= 1'b1;
                    held_idx   <= scan_idx;
                    held_age   <= slot_age[scan_idx];
                end
                scan_idx <= scan_idx + 1'b1;
            end
        end
    end

    // Commit decision
    always_comb begin
        do_load     = 1'b0;
        drop        = 1'b0;
        target      = '0;
        release_vec = '0;
        if (state == COMMIT) begin
            if (ev_on_q) begin
                if (match_found) begin
                    do_load = 1'b1;
                    target  = match_idx;
                end else if (free_found) begin
                    do_load = 1'b1;
                    target  = free_idx;
                end else if (STEAL_EN && rel_found) begin
                    do_load = 1'b1;
                    target  = rel_idx;
                end else if (STEAL_EN && held_found) begin
                    do_load = 1'b1;
                    target  = held_idx;
                end else begin
                    drop = 1'b1;
                end
            end else begin
                for (int i = 0; i < NUM_VOICES; i++)
                    release_vec[i] = (slot_note[i] == ev_note_q);
            end
        end
        for (int i = 0; i < NUM_VOICES; i++)
            load_vec[i] = do_load && (target == IDX_W'(i));
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_alloc_slot #(
            .NOTE_W (NOTE_W),
            .AGE_W  (AGE_W)
        ) u_slot (
            .clk         (clk_clk),
            .rst         (reset_reset),
            .load        (load_vec[g]),
            .load_note   (ev_note_q),
            .load_vel    (ev_vel_q),
            .release_req (release_vec[g]),
            .done        (voice_done[g]),
            .age_inc     (do_load),
            .state       (slot_state[g]),
            .note        (slot_note[g]),
            .vel         (slot_vel[g]),
            .age         (slot_age[g]),
            .trig        (slot_trig[g])
        );

        assign voice_gate[g] = (slot_state[g] == HELD);
        assign voice_trig[g] = slot_trig[g];
        assign voice_note[g*NOTE_W +: NOTE_W] = slot_note[g];
        assign voice_vel[g*NOTE_W +: NOTE_W]  = slot_vel[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Directed self-checking bench for voice_allocator (NUM_VOICES=8, NOTE_W=7).
module tb_voice_allocator;

    localparam int NV = 8;
    localparam int NW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic          ev_on = 1'b0;
    logic [NW-1:0] ev_note = '0;
    logic [NW-1:0] ev_vel = '0;
    logic [NV-1:0] voice_done = '0;
    logic [NV-1:0] voice_gate;
    logic [NV-1:0] voice_trig;
    logic [NV*NW-1:0] voice_note;
    logic [NV*NW-1:0] voice_vel;
    logic          ev_dropped;

    int checks = 0;
    int passed = 0;

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .AGE_W(8)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_on       (ev_on),
        .ev_note     (ev_note),
        .ev_vel      (ev_vel),
        .voice_done  (voice_done),
        .voice_gate  (voice_gate),
        .voice_trig  (voice_trig),
        .voice_note  (voice_note),
        .voice_vel   (voice_vel),
        .ev_dropped  (ev_dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [NW-1:0] note_of(input int i);
        return voice_note[i*NW +: NW];
    endfunction

    function automatic logic [NW-1:0] vel_of(input int i);
        return voice_vel[i*NW +: NW];
    endfunction

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents an event for one edge; returns in cycle 1 after the accept edge.
    task automatic send_event(input logic on, input int note, input int vel);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = NW'(note);
        ev_vel   = NW'(vel);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        ev_vel   = '0;
    endtask

    // Full event: returns in cycle 10, where trig/dropped are visible.
    task automatic do_event(input logic on, input int note, input int vel);
        send_event(on, note, vel);
        step(9);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (voice_gate !== 8'h00) $display("FAIL reset_gate got %h want 00", voice_gate); else passed++;
        checks++; if (voice_trig !== 8'h00) $display("FAIL reset_trig got %h want 00", voice_trig); else passed++;
        checks++; if (voice_note !== '0) $display("FAIL reset_note got %h want 0", voice_note); else passed++;
        checks++; if (voice_vel !== '0) $display("FAIL reset_vel got %h want 0", voice_vel); else passed++;
        checks++; if (ev_dropped !== 1'b0) $display("FAIL reset_dropped got %b want 0", ev_dropped); else passed++;
        checks++; if (ev_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ev_ready); else passed++;
    endtask

    task automatic test_note_on();
        int bad_ready;
        int bad_trig;
        apply_reset();
        bad_ready = 0;
        bad_trig  = 0;
        send_event(1'b1, 60, 100);
        for (int c = 1; c <= 9; c++) begin
            if (ev_ready !== 1'b0) bad_ready++;
            if (voice_trig !== 8'h00) bad_trig++;
            step(1);
        end
        checks++; if (bad_ready != 0) $display("FAIL busy_ready high %0d cycles want 0", bad_ready); else passed++;
        checks++; if (bad_trig != 0) $display("FAIL early_trig high %0d cycles want 0", bad_trig); else passed++;
        checks++; if (voice_trig !== 8'h01) $display("FAIL on_trig got %h want 01", voice_trig); else passed++;
        checks++; if (ev_ready !== 1'b1) $display("FAIL on_ready got %b want 1", ev_ready); else passed++;
        checks++; if (voice_gate !== 8'h01) $display("FAIL on_gate got %h want 01", voice_gate); else passed++;
        checks++; if (note_of(0) !== 7'd60) $display("FAIL on_note got %0d want 60", note_of(0)); else passed++;
        checks++; if (vel_of(0) !== 7'd100) $display("FAIL on_vel got %0d want 100", vel_of(0)); else passed++;
        step(1);
        checks++; if (voice_trig !== 8'h00) $display("FAIL trig_width got %h want 00", voice_trig); else passed++;
    endtask

    task automatic test_release();
        // Slot 0 holds note 60 from the previous test.
        do_event(1'b0, 60, 0);
        checks++; if (voice_gate !== 8'h00) $display("FAIL off_gate got %h want 00", voice_gate); else passed++;
        checks++; if (voice_trig !== 8'h00) $display("FAIL off_trig got %h want 00", voice_trig); else passed++;
        checks++; if (note_of(0) !== 7'd60) $display("FAIL off_note_hold got %0d want 60", note_of(0)); else passed++;
        voice_done = 8'h01;
        step(1);
        voice_done = 8'h00;
        do_event(1'b1, 62, 33);
        checks++; if (voice_gate !== 8'h01) $display("FAIL reuse_gate got %h want 01", voice_gate); else passed++;
        checks++; if (note_of(0) !== 7'd62) $display("FAIL reuse_note got %0d want 62", note_of(0)); else passed++;
        checks++; if (voice_trig !== 8'h01) $display("FAIL reuse_trig got %h want 01", voice_trig); else passed++;
    endtask

    task automatic test_retrigger();
        apply_reset();
        do_event(1'b1, 64, 50);
        // A done pulse on a HELD slot must be ignored.
        voice_done = 8'h01;
        step(1);
        voice_done = 8'h00;
        checks++; if (voice_gate !== 8'h01) $display("FAIL done_on_held gate got %h want 01", voice_gate); else passed++;
        do_event(1'b1, 64, 90);
        checks++; if (voice_gate !== 8'h01) $display("FAIL retrig_gate got %h want 01", voice_gate); else passed++;
        checks++; if (voice_trig !== 8'h01) $display("FAIL retrig_trig got %h want 01", voice_trig); else passed++;
        checks++; if (vel_of(0) !== 7'd90) $display("FAIL retrig_vel got %0d want 90", vel_of(0)); else passed++;
        // Note-off for a note nobody holds changes nothing.
        do_event(1'b0, 99, 0);
        checks++; if (voice_gate !== 8'h01) $display("FAIL off_nomatch gate got %h want 01", voice_gate); else passed++;
    endtask

    task automatic test_full();
        int bad_note;
        apply_reset();
        for (int n = 0; n < NV; n++) do_event(1'b1, 60 + n, 10 + n);
        bad_note = 0;
        for (int n = 0; n < NV; n++) if (note_of(n) !== NW'(60 + n)) bad_note++;
        checks++; if (voice_gate !== 8'hFF) $display("FAIL fill_gate got %h want ff", voice_gate); else passed++;
        checks++; if (bad_note != 0) $display("FAIL fill_notes wrong %0d slots want 0", bad_note); else passed++;
        do_event(1'b1, 70, 77);
`ifdef VOICE_STEAL_EN
        checks++; if (note_of(0) !== 7'd70) $display("FAIL steal_note got %0d want 70", note_of(0)); else passed++;
        checks++; if (voice_trig !== 8'h01) $display("FAIL steal_trig got %h want 01", voice_trig); else passed++;
        checks++; if (ev_dropped !== 1'b0) $display("FAIL steal_dropped got %b want 0", ev_dropped); else passed++;
`else
        checks++; if (ev_dropped !== 1'b1) $display("FAIL drop_pulse got %b want 1", ev_dropped); else passed++;
        checks++; if (voice_trig !== 8'h00) $display("FAIL drop_trig got %h want 00", voice_trig); else passed++;
        checks++; if (note_of(0) !== 7'd60) $display("FAIL drop_note got %0d want 60", note_of(0)); else passed++;
`endif
        checks++; if (voice_gate !== 8'hFF) $display("FAIL full_gate got %h want ff", voice_gate); else passed++;
        step(1);
        checks++; if (ev_dropped !== 1'b0) $display("FAIL dropped_width got %b want 0", ev_dropped); else passed++;
    endtask

    task automatic test_vel_zero();
        apply_reset();
        do_event(1'b1, 60, 40);
        do_event(1'b1, 61, 41);
        checks++; if (voice_gate !== 8'h03) $display("FAIL vz_setup gate got %h want 03", voice_gate); else passed++;
        do_event(1'b1, 61, 0);
        checks++; if (voice_gate !== 8'h01) $display("FAIL vz_gate got %h want 01", voice_gate); else passed++;
        checks++; if (voice_trig !== 8'h00) $display("FAIL vz_trig got %h want 00", voice_trig); else passed++;
    endtask

    task automatic test_reset_mid_scan();
        int trig_seen;
        apply_reset();
        send_event(1'b1, 60, 100);
        step(3);
        rst = 1'b1;
        #3;
        checks++; if (voice_gate !== 8'h00 || voice_note !== '0 || voice_vel !== '0)
            $display("FAIL midrst_outputs gate %h note %h vel %h want all 0", voice_gate, voice_note, voice_vel);
        else passed++;
        rst = 1'b0;
        step(1);
        checks++; if (ev_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", ev_ready); else passed++;
        trig_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (voice_trig !== 8'h00 || voice_gate !== 8'h00) trig_seen++;
            step(1);
        end
        checks++; if (trig_seen != 0) $display("FAIL midrst_trig activity %0d cycles want 0", trig_seen); else passed++;
    endtask

    task automatic test_back_to_back();
        // Events offered immediately as ready returns go to successive slots.
        apply_reset();
        do_event(1'b1, 40, 1);
        do_event(1'b1, 41, 2);
        do_event(1'b1, 42, 3);
        checks++; if (voice_gate !== 8'h07) $display("FAIL b2b_gate got %h want 07", voice_gate); else passed++;
        checks++; if (note_of(2) !== 7'd42 || vel_of(2) !== 7'd3)
            $display("FAIL b2b_slot2 note %0d vel %0d want 42 3", note_of(2), vel_of(2));
        else passed++;
        checks++; if (voice_trig !== 8'h04) $display("FAIL b2b_trig got %h want 04", voice_trig); else passed++;
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_release();
        test_retrigger();
        test_full();
        test_vel_zero();
        test_reset_mid_scan();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator between the MIDI event source (Nios keycode/event path) and the synthesizer voice bank. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of NUM_VOICES voice slots. It drives per-voice gate, note, velocity and retrigger signals to the oscillator/envelope datapath. Freed voices are returned when their envelopes report release completion.

## Interface
- NUM_VOICES, 8: voice slots; 2..32.
- NOTE_W, 7: MIDI note and velocity width.
- AGE_W, 8: per-voice saturating age counter width.
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  NOTE_W  MIDI note number.
- ev_vel  in  NOTE_W  velocity; note-on with 0 is treated as note-off.
- voice_done  in  NUM_VOICES  per-voice envelope-release-finished pulse.
- voice_gate  out  NUM_VOICES  voice held (key down).
- voice_trig  out  NUM_VOICES  one-cycle envelope (re)start pulse.
- voice_note  out  NUM_VOICES*NOTE_W  note per voice, slot i at [i*NOTE_W +: NOTE_W].
- voice_vel  out  NUM_VOICES*NOTE_W  velocity per voice, same packing.
- ev_dropped  out  1  one-cycle pulse: note-on discarded.

## Operation
- Per-voice state: FREE, HELD (gate=1), RELEASING (gate=0, envelope still sounding).
- Controller FSM: IDLE -> SCAN -> COMMIT -> IDLE. ev_ready=1 only in IDLE. Accept on ev_valid&&ev_ready, latching on/note/vel.
- SCAN: evaluates one slot per cycle, index 0..NUM_VOICES-1. It tracks these candidates:
  - the first slot with a matching note in HELD or RELEASING;
  - the first FREE slot;
  - the oldest RELEASING slot;
  - the oldest HELD slot.
  - Age ties resolve to the lowest index.
- COMMIT for note-on, by priority:
  - matching slot: retrigger with the new velocity;
  - else the first FREE slot;
  - else steal (see Configuration).
  - The chosen slot goes HELD, note/vel are loaded, trig is pulsed and its age is set to 0.
  - Ages of all other non-FREE slots increment, saturating at 2^AGE_W-1.
- COMMIT for note-off: every HELD slot with a matching note goes RELEASING (gate 0). No match: no effect. Ages are unchanged.
- voice_done[i]:
  - RELEASING -> FREE, age cleared.
  - Ignored in FREE or HELD.
  - Ignored for the slot being assigned in the same COMMIT cycle; COMMIT wins.
  - Applied in any FSM state.
  - A slot freed after SCAN has passed its index is not a candidate for the current event.
- voice_note and voice_vel hold their last values when a slot is FREE.

## Timing
- Event accepted at edge 0. SCAN occupies cycles 1..NUM_VOICES, COMMIT cycle NUM_VOICES+1.
- Gate, note, vel and ev_dropped update at the end of COMMIT. voice_trig is high for exactly cycle NUM_VOICES+2, and ev_ready returns high in that same cycle.
- Throughput: one event per NUM_VOICES+2 cycles.
- Reset values:
  - all slots FREE, ages 0;
  - voice_gate=0, voice_trig=0, voice_note=0, voice_vel=0;
  - ev_dropped=0, FSM IDLE, ev_ready=1.
- Reset asserted mid-SCAN or mid-COMMIT: the in-flight event is discarded and no outputs change other than to their reset values.
- ev_on/ev_note/ev_vel are sampled only at accept. Changes while not ready are ignored.

## Configuration
- VOICE_STEAL_EN defined, with no match and no FREE slot:
  - take the oldest RELEASING slot, else the oldest HELD slot;
  - the stolen slot gets a trig pulse and ev_dropped stays 0.
- VOICE_STEAL_EN undefined: the note-on is discarded, ev_dropped pulses in cycle NUM_VOICES+2, and no slot changes.

## Structure
- Shared package synth_voice_pkg holds:
  - voice_state_t enum (FREE/HELD/RELEASING);
  - alloc_state_t enum (IDLE/SCAN/COMMIT);
  - NOTE_W default constant.
- Sub-module voice_alloc_slot, instantiated NUM_VOICES times. It owns one slot's state, note, vel and age register, and its load/release/done/age-increment controls.
- The top level holds the FSM, the scan index and the candidate registers.

## Test plan
- Reset, then note-on 60 vel 100:
  - slot 0 gate=1, note=60, vel=100;
  - voice_trig[0] pulses in cycle 10 (NUM_VOICES=8);
  - ev_ready low for cycles 1..9.
- Note-on 60, then note-off 60: gate[0]=0. voice_done[0] pulse -> slot 0 FREE. Next note-on 62 lands in slot 0.
- Note-on 64 vel 50, then note-on 64 vel 90: the same slot retriggers with vel=90 and no second slot is used.
- Note-on 60..67 fill all 8 slots, then note-on 70:
  - with VOICE_STEAL_EN, slot 0 (oldest) gets note 70 and trig;
  - without it, ev_dropped pulses and all slots are unchanged.
- Note-on vel 0 for a held note 61: handled as note-off, gate drops.
- reset_reset asserted during SCAN of note-on 60: all outputs at reset values, no trig, ev_ready=1 after release.
